dma_priority_arbiter: RTL and testbench
=======================================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter: HLDA_TIMEOUT, default 255, max cycles in HOLD_REQ waiting for HLDA before abandoning (range 1..255).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset; deassertion synchronous to CLK.
REQ-004 DREQ  input  4  raw channel DMA requests, polarity per dreqSenseLow.
REQ-005 HLDA  input  1  hold acknowledge from CPU, active-high.
REQ-006 EOP_N  input  1  end-of-process from timing/control, active-low, sampled on CLK.
REQ-007 mask  input  4  per-channel request mask; 1 = channel ignored.
REQ-008 swReq  input  4  software requests; bypass mask and sense polarity.
REQ-009 rotPri  input  1  1 = rotating priority, 0 = fixed priority.
REQ-010 dreqSenseLow  input  1  1 = DREQ active-low.
REQ-011 dackSenseHigh  input  1  1 = DACK active-high, 0 = active-low.
REQ-012 ctrlDisable  input  1  1 = no new request accepted.
REQ-013 HRQ  output  1  hold request to CPU, registered, active-high.
REQ-014 DACK  output  4  channel acknowledges, polarity per dackSenseHigh.
REQ-015 activeCh  output  2  channel currently granted; 0 when not ACTIVE.
REQ-016 busy  output  1  high only in ACTIVE.
REQ-017 timeoutErr  output  1  one-cycle pulse on HLDA timeout.

Function
REQ-018 Effective request eff[i] = (((DREQ[i] ^ dreqSenseLow) & ~mask[i]) | swReq[i]) & ~ctrlDisable, combinational.
REQ-019 FSM states: IDLE, HOLD_REQ, ACTIVE, RELEASE; reset state IDLE.
REQ-020 IDLE: HRQ=0; if any eff=1, go HOLD_REQ; HRQ=1 starting the first cycle after request sampled (1-cycle latency).
REQ-021 HOLD_REQ: HRQ=1; 8-bit wait counter increments each cycle from 0.
REQ-022 HOLD_REQ, HLDA=1 and any eff=1: latch winner from eff by current priority, go ACTIVE; DACK of winner asserted the cycle after HLDA sampled.
REQ-023 HOLD_REQ, all eff=0 before HLDA: go IDLE, HRQ=0 next cycle, no DACK.
REQ-024 HOLD_REQ, counter reaches HLDA_TIMEOUT without HLDA: go IDLE, HRQ=0, timeoutErr=1 for one cycle; HLDA and timeout in same cycle -> HLDA wins.
REQ-025 ACTIVE: exactly one DACK active, activeCh=winner, busy=1, HRQ=1; other requests never preempt.
REQ-026 ACTIVE exits to RELEASE when any of: EOP_N=0 sampled, HLDA=0 sampled, eff[winner]=0 (includes masking or ctrlDisable mid-service).
REQ-027 RELEASE: all DACK inactive, HRQ=0, busy=0, lasts exactly one cycle, then IDLE; guarantees ≥2 cycles HRQ low between grants.
REQ-028 Fixed priority: channel 0 highest, 3 lowest.
REQ-029 Rotating priority: 2-bit pointer = highest-priority channel; on RELEASE from service of channel k, pointer = (k+1) mod 4; order pointer, pointer+1, … wrapping mod 4.
REQ-030 Pointer updates only in RELEASE and only when rotPri=1; pointer retained when rotPri toggles; reset value 0.
REQ-031 DACK[i] = grantOH[i] when dackSenseHigh=1, else ~grantOH[i]; grantOH registered one-hot, all-zero outside ACTIVE.
REQ-032 Config inputs (mask, polarity, rotPri) are used as sampled each cycle; no internal shadow copies.

Reset
REQ-033 RESET_N=0 at any time, including mid-ACTIVE: immediately state=IDLE, HRQ=0, grantOH=0 (DACK inactive per dackSenseHigh), activeCh=0, busy=0, timeoutErr=0, counter=0, pointer=0.
REQ-034 First request after RESET_N rises is evaluated on the first rising CLK edge following deassertion.

Verification
REQ-035 Fixed priority: DREQ=4'b1010, rotPri=0, HLDA asserted 2 cycles after HRQ -> DACK[1] only, activeCh=1; EOP_N pulse -> RELEASE, then DACK[3] on next grant.
REQ-036 Rotating: all four DREQ held, rotPri=1, EOP_N after each grant -> grant order 0,1,2,3,0.
REQ-037 Timeout: HLDA_TIMEOUT=4, DREQ[2]=1, HLDA never -> HRQ high 4 cycles in HOLD_REQ, then HRQ=0 and timeoutErr single pulse.
REQ-038 Mask mid-service: ch0 ACTIVE, set mask[0]=1 -> DACK[0] drops next cycle, HRQ low one cycle in RELEASE; swReq[0]=1 instead -> channel still granted despite mask.
REQ-039 Polarity: dreqSenseLow=1, dackSenseHigh=0, DREQ=4'b1110 -> ch0 granted, DACK=4'b1110; at reset DACK=4'b1111.
REQ-040 Reset mid-ACTIVE: RESET_N low while ch3 granted -> HRQ=0, busy=0, DACK inactive without waiting for a CLK edge.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: request, hold handshake, configuration and grant signals of the DMA arbiter
interface dma_priority_arbiter_if;
  logic [3:0] dreq;
  logic       hlda;
  logic       eop_n;
  logic [3:0] mask;
  logic [3:0] sw_req;
  logic       rot_pri;
  logic       dreq_sense_low;
  logic       dack_sense_high;
  logic       ctrl_disable;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       busy;
  logic       timeout_err;
  modport master (
    output dreq, hlda, eop_n, mask, sw_req, rot_pri, dreq_sense_low, dack_sense_high, ctrl_disable,
    input  hrq, dack, active_ch, busy, timeout_err
  );
  modport slave (
    input  dreq, hlda, eop_n, mask, sw_req, rot_pri, dreq_sense_low, dack_sense_high, ctrl_disable,
    output hrq, dack, active_ch, busy, timeout_err
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: four-channel DMA request arbiter with CPU hold handshake and fixed/rotating priority
module dma_priority_arbiter #(
  parameter int HLDA_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  dma_priority_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOLD_REQ = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;
  logic [1:0] state, nxt;
  logic [7:0] cnt;
  logic [1:0] ptr, base, pick, winner;
  logic [3:0] eff, grant_oh;
  logic       any_eff, timeout_hit, exit_active;
  logic       hrq_q, busy_q, terr_q;
  assign eff         = (((bus.dreq ^ {4{bus.dreq_sense_low}}) & ~bus.mask) | bus.sw_req) & ~{4{bus.ctrl_disable}};
  assign any_eff     = |eff;
  assign timeout_hit = cnt == 8'(HLDA_TIMEOUT - 1);
  assign exit_active = !bus.eop_n || !bus.hlda || !eff[winner];
  assign base        = bus.rot_pri ? ptr : 2'd0;
  // first requesting channel scanning upward from the current highest-priority slot
  always_comb begin
    pick = base;
    for (int i = 3; i >= 0; i--)
      if (eff[base + 2'(i)]) pick = base + 2'(i);
  end
  // next-state decode; HLDA outranks a timeout landing in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = any_eff ? HOLD_REQ : IDLE;
      HOLD_REQ: nxt = !any_eff ? IDLE : bus.hlda ? ACTIVE : timeout_hit ? IDLE : HOLD_REQ;
      ACTIVE:   nxt = exit_active ? RELEASE : ACTIVE;
      default:  nxt = IDLE;
    endcase
  end
  // state, wait counter and rotating pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      ptr   <= 2'd0;
    end else begin
      state <= nxt;
      cnt   <= (state == HOLD_REQ && nxt == HOLD_REQ) ? cnt + 8'd1 : 8'd0;
      ptr   <= (state == RELEASE && bus.rot_pri) ? winner + 2'd1 : ptr;
    end
  end
  // winner latch and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner   <= 2'd0;
      grant_oh <= 4'b0;
      hrq_q    <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      winner   <= (state == HOLD_REQ && nxt == ACTIVE) ? pick : winner;
      grant_oh <= nxt != ACTIVE ? 4'b0 : state == ACTIVE ? grant_oh : 4'b0001 << pick;
      hrq_q    <= nxt == HOLD_REQ || nxt == ACTIVE;
      busy_q   <= nxt == ACTIVE;
      terr_q   <= state == HOLD_REQ && any_eff && !bus.hlda && timeout_hit;
    end
  end
  assign bus.hrq         = hrq_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.active_ch   = busy_q ? winner : 2'd0;
  assign bus.dack        = bus.dack_sense_high ? grant_oh : ~grant_oh;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: scenario tasks with a queue of expected grant channels
module tb_dma_priority_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  always #5 clk = ~clk;
  dma_priority_arbiter_if bus();
  dma_priority_arbiter #(.HLDA_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.dreq = 4'b0; bus.hlda = 1'b0; bus.eop_n = 1'b1; bus.mask = 4'b0; bus.sw_req = 4'b0;
    bus.rot_pri = 1'b0; bus.dreq_sense_low = 1'b0; bus.dack_sense_high = 1'b1; bus.ctrl_disable = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_grant(output logic [1:0] ch, output logic [3:0] dk, output bit ok);
    ch = 2'd0; dk = 4'b0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (bus.hrq === 1'b1) ok = 1'b1; end
    if (!ok) return;
    @(negedge clk);
    bus.hlda = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin @(negedge clk); if (bus.busy === 1'b1) ok = 1'b1; end
    ch = bus.active_ch;
    dk = bus.dack;
  endtask

  task automatic end_service();
    bus.eop_n = 1'b0;
    @(negedge clk);
    bus.eop_n = 1'b1;
    bus.hlda = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq got %b need 0", bus.hrq); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", bus.busy); end
    checks++; if (bus.dack !== 4'b0000) begin errors++; $display("FAIL reset_dack got %b need 0000", bus.dack); end
    checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch got %0d need 0", bus.active_ch); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b need 0", bus.timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    logic [1:0] ch; logic [3:0] dk, ed; bit ok; int e;
    apply_reset();
    bus.dreq = 4'b1010;
    exp_q.push_back(1); exp_q.push_back(3);
    for (int n = 0; n < 2; n++) begin
      do_grant(ch, dk, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fixed_grant_wait got no grant need grant %0d", n); end
      e = exp_q.pop_front();
      ed = 4'b0001 << e;
      checks++; if (ch !== 2'(e)) begin errors++; $display("FAIL fixed_active_ch got %0d need %0d", ch, e); end
      checks++; if (dk !== ed) begin errors++; $display("FAIL fixed_dack got %b need %b", dk, ed); end
      end_service();
      checks++; if (bus.hrq !== 1'b0 || bus.busy !== 1'b0 || bus.dack !== 4'b0000)
        begin errors++; $display("FAIL fixed_release got hrq=%b busy=%b dack=%b need 0 0 0000", bus.hrq, bus.busy, bus.dack); end
      bus.dreq = 4'b1000 & {4{n == 0}};
    end
  endtask

  task automatic test_rotating();
    logic [1:0] ch; logic [3:0] dk, ed; bit ok; int e;
    apply_reset();
    bus.rot_pri = 1'b1;
    bus.dreq = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int n = 0; n < 5; n++) begin
      do_grant(ch, dk, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rot_grant_wait got no grant need grant %0d", n); end
      e = exp_q.pop_front();
      ed = 4'b0001 << e;
      checks++; if (ch !== 2'(e)) begin errors++; $display("FAIL rot_active_ch got %0d need %0d", ch, e); end
      checks++; if (dk !== ed) begin errors++; $display("FAIL rot_dack got %b need %b", dk, ed); end
      end_service();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    apply_reset();
    bus.dreq = 4'b0100;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); if (bus.hrq === 1'b1) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_hrq_rise got 0 need 1"); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.hrq !== 1'b1 || bus.timeout_err !== 1'b0)
        begin errors++; $display("FAIL timeout_hold_%0d got hrq=%b terr=%b need 1 0", i, bus.hrq, bus.timeout_err); end
    end
    @(negedge clk);
    checks++; if (bus.hrq !== 1'b0 || bus.timeout_err !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL timeout_fire got hrq=%b terr=%b busy=%b need 0 1 0", bus.hrq, bus.timeout_err, bus.busy); end
    bus.dreq = 4'b0;
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b need 0", bus.timeout_err); end
  endtask

  task automatic test_mask_mid_service();
    logic [1:0] ch; logic [3:0] dk; bit ok; int e;
    apply_reset();
    bus.dreq = 4'b0001;
    exp_q.push_back(0);
    do_grant(ch, dk, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ch !== 2'(e)) begin errors++; $display("FAIL mask_grant got ok=%b ch=%0d need 1 %0d", ok, ch, e); end
    bus.mask = 4'b0001;
    @(negedge clk);
    checks++; if (bus.dack !== 4'b0000 || bus.hrq !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL mask_drop got dack=%b hrq=%b busy=%b need 0000 0 0", bus.dack, bus.hrq, bus.busy); end
    bus.hlda = 1'b0;
    @(negedge clk);
    checks++; if (bus.hrq !== 1'b0) begin errors++; $display("FAIL mask_idle_hrq got %b need 0", bus.hrq); end
    bus.mask = 4'b0;
    exp_q.push_back(0);
    do_grant(ch, dk, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ch !== 2'(e)) begin errors++; $display("FAIL sw_grant got ok=%b ch=%0d need 1 %0d", ok, ch, e); end
    bus.mask = 4'b0001;
    bus.sw_req = 4'b0001;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.active_ch !== 2'd0 || bus.dack !== 4'b0001)
      begin errors++; $display("FAIL sw_hold got busy=%b ch=%0d dack=%b need 1 0 0001", bus.busy, bus.active_ch, bus.dack); end
    end_service();
    idle_inputs();
  endtask

  task automatic test_polarity();
    logic [1:0] ch; logic [3:0] dk, ed; bit ok; int e;
    rst_n = 1'b0;
    bus.dreq_sense_low = 1'b1;
    bus.dack_sense_high = 1'b0;
    bus.dreq = 4'b1111;
    #1;
    checks++; if (bus.dack !== 4'b1111) begin errors++; $display("FAIL pol_reset_dack got %b need 1111", bus.dack); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.dreq = 4'b1110;
    exp_q.push_back(0);
    do_grant(ch, dk, ok);
    e = exp_q.pop_front();
    ed = ~(4'b0001 << e);
    checks++; if (!ok || ch !== 2'(e)) begin errors++; $display("FAIL pol_grant got ok=%b ch=%0d need 1 %0d", ok, ch, e); end
    checks++; if (dk !== ed) begin errors++; $display("FAIL pol_dack got %b need %b", dk, ed); end
    end_service();
    checks++; if (bus.dack !== 4'b1111) begin errors++; $display("FAIL pol_release_dack got %b need 1111", bus.dack); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_withdraw_and_disable();
    bit ok = 1'b0;
    apply_reset();
    bus.dreq = 4'b0010;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); if (bus.hrq === 1'b1) ok = 1'b1; end
    bus.dreq = 4'b0;
    @(negedge clk);
    checks++; if (!ok || bus.hrq !== 1'b0 || bus.dack !== 4'b0000)
      begin errors++; $display("FAIL withdraw got ok=%b hrq=%b dack=%b need 1 0 0000", ok, bus.hrq, bus.dack); end
    bus.ctrl_disable = 1'b1;
    bus.dreq = 4'b0001;
    bus.sw_req = 4'b0100;
    repeat (4) @(negedge clk);
    checks++; if (bus.hrq !== 1'b0) begin errors++; $display("FAIL disable_hrq got %b need 0", bus.hrq); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_active();
    logic [1:0] ch; logic [3:0] dk; bit ok; int e;
    apply_reset();
    bus.dreq = 4'b1000;
    exp_q.push_back(3);
    do_grant(ch, dk, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ch !== 2'(e) || dk !== 4'b1000)
      begin errors++; $display("FAIL rst_mid_grant got ok=%b ch=%0d dack=%b need 1 %0d 1000", ok, ch, dk, e); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.hrq !== 1'b0 || bus.busy !== 1'b0 || bus.dack !== 4'b0000 || bus.active_ch !== 2'd0)
      begin errors++; $display("FAIL rst_mid_async got hrq=%b busy=%b dack=%b ch=%0d need 0 0 0000 0", bus.hrq, bus.busy, bus.dack, bus.active_ch); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_timeout();
    test_mask_mid_service();
    test_polarity();
    test_withdraw_and_disable();
    test_reset_mid_active();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d entries need 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
